// File: rtl/alu_result_serializer_if.sv
// Valid/ack/data channel shared by the ALU result, ALU overflow and merged word streams.
interface data_interface #(
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic                  valid;
  logic                  ack;
  logic [DATA_WIDTH-1:0] data;

  modport producer (output valid, output data, input ack);
  modport consumer (input valid, input data, output ack);
endinterface

// File: rtl/alu_result_serializer.sv
// Merges the ALU result/overflow channels into one tagged word stream through a register FIFO.
// Result word goes first, then its overflow word; tag = 1 marks overflow words.
module alu_result_serializer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic              clock,
  input  logic              resetn,
  data_interface.consumer   result,
  data_interface.consumer   overflow,
  data_interface.producer   word,
  output logic              word_is_overflow
);

  localparam int unsigned PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W     = PTR_WIDTH + 1;

  typedef struct packed {
    logic                  tag;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t               mem_q [DEPTH];
  logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0] ovf_ptr;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [CNT_W-1:0]     free;
  logic [CNT_W-1:0]     n_push;
  logic                 in_ack;
  logic                 push_res;
  logic                 push_ovf;
  logic                 pop;
  logic                 not_empty;

  always_comb begin
    free      = CNT_W'(DEPTH) - count_q;
    // Room for a whole pair is required even for a single word, so pairs never split.
    in_ack    = (free >= CNT_W'(2)) && resetn;
    push_res  = in_ack && result.valid;
    push_ovf  = in_ack && overflow.valid;
    n_push    = CNT_W'(push_res) + CNT_W'(push_ovf);
    not_empty = (count_q != '0);
    pop       = not_empty && word.ack;
    ovf_ptr   = push_res ? wr_ptr_q + PTR_WIDTH'(1) : wr_ptr_q;
    wr_ptr_d  = wr_ptr_q + PTR_WIDTH'(n_push);
    rd_ptr_d  = rd_ptr_q + PTR_WIDTH'(pop);
    count_d   = count_q + n_push - CNT_W'(pop);
  end

  always_comb begin
    result.ack       = in_ack;
    overflow.ack     = in_ack;
    word.valid       = not_empty;
    word.data        = not_empty ? mem_q[rd_ptr_q].data : '0;
    word_is_overflow = not_empty ? mem_q[rd_ptr_q].tag : 1'b0;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Storage needs no reset: entries are only visible while count covers them.
  always_ff @(posedge clock) begin
    if (push_res) begin
      mem_q[wr_ptr_q] <= '{tag: 1'b0, data: result.data};
    end
    if (push_ovf) begin
      mem_q[ovf_ptr] <= '{tag: 1'b1, data: overflow.data};
    end
  end

endmodule
